// File: rtl/vend_ctrl_multi_if.sv
// vend_ctrl_multi_if: front-end inputs (btn, coin_valid, coin_value, cancel) and controller outputs (product_sel, delivered, credit, change, change_valid, coin_reject, busy)
interface vend_ctrl_multi_if #(
  parameter int N_PROD   = 3,
  parameter int CREDIT_W = 8
);
  logic [N_PROD-1:0]   btn;
  logic                coin_valid;
  logic [3:0]          coin_value;
  logic                cancel;
  logic [N_PROD-1:0]   product_sel;
  logic                delivered;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] change;
  logic                change_valid;
  logic                coin_reject;
  logic                busy;
  modport master (
    output btn, coin_valid, coin_value, cancel,
    input  product_sel, delivered, credit, change, change_valid, coin_reject, busy
  );
  modport slave (
    input  btn, coin_valid, coin_value, cancel,
    output product_sel, delivered, credit, change, change_valid, coin_reject, busy
  );
endinterface

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: N-product vending FSM with coin credit, change, cancel/refund and timeout; ports clk, reset, bus (vend_ctrl_multi_if.slave)
module vend_ctrl_multi #(
  parameter int                         N_PROD      = 3,
  parameter int                         CREDIT_W    = 8,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES      = {8'd5, 8'd3, 8'd2},
  parameter int                         MAX_CREDIT  = 99,
  parameter int                         TIMEOUT_CYC = 1000
) (
  input logic              clk,
  input logic              reset,
  vend_ctrl_multi_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, SELECTED, VEND, REFUND} state_t;
  state_t              state;
  logic [TW-1:0]       timer;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] credit_nx;
  logic [N_PROD-1:0]   first;
  logic                coin_ok;
  always_comb begin
    sum       = (CREDIT_W+1)'(bus.credit) + (CREDIT_W+1)'(bus.coin_value);
    coin_ok   = bus.coin_valid && |bus.coin_value && sum <= (CREDIT_W+1)'(MAX_CREDIT) &&
                (state == IDLE || (state == SELECTED && !bus.cancel));
    credit_nx = coin_ok ? sum[CREDIT_W-1:0] : bus.credit;
    first     = bus.btn & (~bus.btn + N_PROD'(1));
    price     = '0;
    for (int i = 0; i < N_PROD; i++)
      price = bus.product_sel[i] ? PRICES[i*CREDIT_W +: CREDIT_W] : price;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      timer            <= '0;
      bus.product_sel  <= '0;
      bus.delivered    <= 1'b0;
      bus.credit       <= '0;
      bus.change       <= '0;
      bus.change_valid <= 1'b0;
      bus.coin_reject  <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.delivered    <= 1'b0;
      bus.change_valid <= 1'b0;
      bus.coin_reject  <= bus.coin_valid && !coin_ok;
      bus.credit       <= credit_nx;
      case (state)
        IDLE:
          if (|bus.btn) begin
            bus.product_sel <= first;
            timer           <= '0;
            bus.busy        <= 1'b1;
            state           <= SELECTED;
          end else if (bus.cancel && |bus.credit) begin
            bus.change       <= credit_nx;
            bus.change_valid <= 1'b1;
            bus.busy         <= 1'b1;
            state            <= REFUND;
          end
        SELECTED:
          if (bus.cancel) begin
            bus.change       <= bus.credit;
            bus.change_valid <= 1'b1;
            state            <= REFUND;
          end else if (bus.credit >= price) begin
            bus.delivered    <= 1'b1;
            bus.change       <= credit_nx - price;
            bus.change_valid <= 1'b1;
            state            <= VEND;
          end else if (coin_ok) begin
            timer <= '0;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            bus.change       <= credit_nx;
            bus.change_valid <= 1'b1;
            state            <= REFUND;
          end else begin
            timer <= timer + TW'(1);
          end
        default: begin
          bus.credit      <= '0;
          bus.product_sel <= '0;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised vending controller for N products with per-product prices. It accumulates multi-denomination coin credit and delivers the selected product once credit covers the price. It computes and reports change, supports cancel/refund and an inactivity timeout, and rejects coins that would overflow credit. It sits between the button/coin-acceptor front end and the display/dispense logic, replacing the fixed 3-product controller.

## Interface
Parameters:
- N_PROD, 3, number of products/buttons (1..8)
- CREDIT_W, 8, width of credit/change/price values
- PRICES, {8'd5,8'd3,8'd2}, packed N_PROD×CREDIT_W vector; slice i = price of product i (product 0 = LSB slice)
- MAX_CREDIT, 99, highest credit value accepted; must fit in CREDIT_W
- TIMEOUT_CYC, 1000, number of idle cycles in SELECTED before auto-refund

Ports:
- clk  in  1  single system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- btn  in  N_PROD  product request buttons; lowest set index wins
- coin_valid  in  1  one-cycle strobe: coin present
- coin_value  in  4  coin value, sampled when coin_valid=1
- cancel  in  1  refund request
- product_sel  out  N_PROD  one-hot latched selection; 0 when none
- delivered  out  1  one-cycle dispense pulse
- credit  out  CREDIT_W  current accumulated credit
- change  out  CREDIT_W  change/refund amount; held until the next payout
- change_valid  out  1  one-cycle pulse, coincident with the change load
- coin_reject  out  1  one-cycle pulse: coin returned, not credited
- busy  out  1  high in SELECTED, VEND, REFUND

## Operation
- States: IDLE, SELECTED, VEND, REFUND. All outputs are registered.
- Reset values: state IDLE. product_sel, delivered, credit, change, change_valid, coin_reject, busy and the timer are all 0.
- Coin acceptance is allowed in IDLE and SELECTED only.
  - A coin is credited when coin_value≠0 and credit+coin_value ≤ MAX_CREDIT; the sum is computed at CREDIT_W+1 bits.
  - Otherwise coin_reject pulses and credit is unchanged.
  - Any coin in VEND or REFUND is rejected.
- IDLE:
  - btn≠0: latch the lowest set index into product_sel, clear the timer, go to SELECTED.
  - Otherwise cancel with credit>0: go to REFUND. cancel with credit=0 is ignored.
- SELECTED:
  - cancel: go to REFUND. cancel has priority over a coin in the same cycle; that coin is rejected.
  - Else if credit ≥ PRICES[sel] (registered credit, so a same-cycle coin is not counted): go to VEND.
  - Else if timer = TIMEOUT_CYC-1: go to REFUND.
  - Else increment the timer. An accepted coin clears the timer.
  - btn is ignored; the selection is locked.
- VEND, one cycle:
  - delivered=1, change=credit−PRICES[sel], change_valid=1.
  - credit←0, product_sel←0, go to IDLE.
  - change=0 is still reported with change_valid=1.
- REFUND, one cycle:
  - change=credit, change_valid=1, credit←0, product_sel←0, go to IDLE. delivered stays 0.
- Simultaneous btn and coin in IDLE: both take effect.
- reset asserted in any state: next edge returns to reset values; credit is lost, with no change pulse.

## Timing
- Coin strobe at edge t: credit updated after edge t+1. A rejected coin pulses coin_reject in cycle t+1.
- btn at t: product_sel and busy valid after t+1.
- With prior credit ≥ price: btn at t, SELECTED at t+1, delivered/change_valid high for exactly cycle t+2, IDLE at t+3.
- Paying by the exact coin: coin at t, credit at t+1, VEND at t+2.
- Timeout: REFUND is entered TIMEOUT_CYC cycles after the last credited coin or after selection.
- delivered and change_valid are never high for two consecutive cycles.

## Test plan
- Reset: assert reset 2 cycles mid-SELECTED with credit=4 -> all outputs 0, state IDLE, no change_valid pulse.
- Product 0: btn=001, coins 1 then 1 -> delivered pulse, change=0, change_valid=1, credit returns to 0, product_sel=000.
- Product 2 overpay: btn=100, coins 4 then 4 -> delivered one cycle after credit=8, change=3.
- Cancel: btn=010, coin 2, then cancel together with a coin 1 -> coin_reject=1, REFUND change=2, delivered=0.
- Overflow: MAX_CREDIT=9, coins 5,4,1 in IDLE -> credit=9, third coin rejected; coin_value=0 is also rejected.
- Timeout (TIMEOUT_CYC=8): btn=100, coin 1 -> REFUND with change=1 exactly 8 cycles after the coin credit; a mid-wait coin restarts the count.
